// File: rtl/ram_stream_reader_pkg.sv
//============================================================================
// Module      : ram_stream_reader_pkg
// Description : Shared state encoding, buffer sizing and read-credit helper
//               for the scratch-RAM stream reader.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } rd_state_e;

  // Output skid buffer depth and the width of its occupancy counter
  localparam int RD_BUF_DEPTH = 2;
  localparam int RD_OCC_W     = 2;

  // A new read may go out only if its word is guaranteed a buffer slot when
  // it is captured next cycle: words held (less the one leaving now) plus
  // the word already on the RAM output must leave at least one slot free.
  function automatic logic rd_credit_ok(input logic [RD_OCC_W-1:0] occ,
                                        input logic                in_flight,
                                        input logic                pop);
    logic [RD_OCC_W:0] load;
    load = {1'b0, occ} + {{RD_OCC_W{1'b0}}, in_flight}
         - {{RD_OCC_W{1'b0}}, pop};
    return load < RD_BUF_DEPTH[RD_OCC_W:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_skid_buf.sv
//============================================================================
// Module      : stream_skid_buf
// Description : Two-entry valid/ready buffer with registered head outputs.
//               Absorbs the words returned by the RAM while the downstream
//               consumer stalls.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module stream_skid_buf
  import ram_stream_reader_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [DW-1:0]       i_push_data,
  input  logic                i_pop,
  output logic [DW-1:0]       o_data,
  output logic                o_valid,
  output logic [RD_OCC_W-1:0] o_count
);

  localparam logic [RD_OCC_W-1:0] c_full = RD_BUF_DEPTH[RD_OCC_W-1:0];

  logic [DW-1:0]       r_head;
  logic [DW-1:0]       r_tail;
  logic [RD_OCC_W-1:0] r_count;
  logic                r_valid;
  logic [RD_OCC_W-1:0] w_count_next;
  logic                w_do_pop;
  logic                w_do_push;

  assign w_do_pop  = i_pop & r_valid;
  // A push into a full buffer is only legal when the head leaves this cycle
  assign w_do_push = i_push & ((r_count != c_full) | w_do_pop);

  // Next occupancy: a simultaneous push and pop leave it unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + RD_OCC_W'(1);
      2'b01:   w_count_next = r_count - RD_OCC_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage update: head always holds the oldest word, tail the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      if (w_do_pop) begin
        if (r_count == c_full) begin
          r_head <= r_tail;
          if (w_do_push) r_tail <= i_push_data;
        end else if (w_do_push) begin
          r_head <= i_push_data;
        end
      end else if (w_do_push) begin
        if (r_count == '0) r_head <= i_push_data;
        else               r_tail <= i_push_data;
      end
    end
  end

  assign o_data  = r_head;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ram_stream_reader.sv
//============================================================================
// Module      : ram_stream_reader
// Description : Burst read sequencer for the registered-read scratch RAM.
//               Issues reads from a base address, retries reads blocked by
//               RAM writes and streams the words out over valid/ready.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ADDR_DW = 4,
  parameter int LEN_W   = ADDR_DW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_DW-1:0] base_addr,
  input  logic [LEN_W-1:0]   len,
  input  logic               wr_busy,
  output logic               RAenable,
  output logic [ADDR_DW-1:0] addr_r,
  input  logic [DW-1:0]      ram_dout,
  output logic [DW-1:0]      m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic               done
);

  rd_state_e           r_state;
  rd_state_e           w_state_next;
  logic                r_done;
  logic                w_done_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_issued;
  logic [LEN_W-1:0]    r_delivered;
  logic [LEN_W-1:0]    w_issued_inc;
  logic [LEN_W-1:0]    w_deliv_inc;
  logic [ADDR_DW-1:0]  r_addr;
  logic                r_inflight;
  logic [RD_OCC_W-1:0] w_occ;
  logic                w_pop;
  logic                w_accept;
  logic                w_start_ok;

  assign w_pop        = m_valid & m_ready;
  assign w_start_ok   = (r_state == S_IDLE) & start & (len != '0);
  assign w_issued_inc = r_issued + LEN_W'(1);
  assign w_deliv_inc  = r_delivered + LEN_W'(1);

  // Read request: registered FETCH state qualified by buffer credit
  assign RAenable = (r_state == S_FETCH) & rd_credit_ok(w_occ, r_inflight, w_pop);
  // The RAM drops reads during its write cycles; those are retried
  assign w_accept = RAenable & ~wr_busy;

  // State and done-pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and done decode
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) w_state_next = S_FETCH;
          else           w_done_next  = 1'b1;
        end
      end
      S_FETCH: begin
        if (w_accept && (w_issued_inc == r_len)) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && (w_deliv_inc == r_len)) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Burst bookkeeping: address, issued/delivered counts, read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_addr      <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_start_ok) begin
        r_len       <= len;
        r_issued    <= '0;
        r_delivered <= '0;
        r_addr      <= base_addr;
      end else begin
        if (w_accept) begin
          r_issued <= w_issued_inc;
          r_addr   <= r_addr + ADDR_DW'(1);
        end
        if (w_pop) r_delivered <= w_deliv_inc;
      end
    end
  end

  // Words land on ram_dout the cycle after acceptance and are captured here
  stream_skid_buf #(
    .DW (DW)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (ram_dout),
    .i_pop       (w_pop),
    .o_data      (m_data),
    .o_valid     (m_valid),
    .o_count     (w_occ)
  );

  assign addr_r = r_addr;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
//============================================================================
// Module      : tb_ram_stream_reader
// Description : Self-checking bench for ram_stream_reader with a RAM
//               responder and a queue-based expected stream.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ram_stream_reader;

  localparam int DW      = 8;
  localparam int ADDR_DW = 4;
  localparam int LEN_W   = 5;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_DW-1:0] base_addr = '0;
  logic [LEN_W-1:0]   len = '0;
  logic               wr_busy = 1'b0;
  logic               RAenable;
  logic [ADDR_DW-1:0] addr_r;
  logic [DW-1:0]      ram_dout = '0;
  logic [DW-1:0]      m_data;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic               busy;
  logic               done;

  logic [DW-1:0]      mem [DEPTH];

  int n_total = 0;
  int n_bad   = 0;

  // Reference state
  logic [DW-1:0]      exp_q [$];
  logic [ADDR_DW-1:0] exp_addr;
  int                 acc_cnt, deliv, done_cnt, stalled;
  bit                 hold_chk;
  logic [DW-1:0]      hold_data;
  int                 ready_mode, busy_mode, pat_i, pulse_left;
  bit                 pulse_done;

  always #5 clk = ~clk;

  // RAM responder: registered read, reads ignored during write cycles
  always @(posedge clk) begin
    if (RAenable && !wr_busy) ram_dout <= mem[addr_r];
  end

  ram_stream_reader #(
    .DW      (DW),
    .ADDR_DW (ADDR_DW),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .wr_busy   (wr_busy),
    .RAenable  (RAenable),
    .addr_r    (addr_r),
    .ram_dout  (ram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the cycle about to be clocked in
  task automatic mon();
    if (RAenable) begin
      chk("rd_addr", 32'(addr_r), 32'(exp_addr));
      if (wr_busy) stalled++;
      else begin
        exp_addr = exp_addr + 1'b1;
        acc_cnt++;
      end
    end
    if (hold_chk) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(hold_data));
    end
    hold_chk  = m_valid && !m_ready;
    hold_data = m_data;
    if (m_valid && m_ready) begin
      deliv++;
      if (exp_q.size() == 0) chk("extra_word", 32'(exp_q.size()), 32'd1);
      else                   chk("data", 32'(m_data), 32'(exp_q.pop_front()));
    end
    chk("busy_done_excl", 32'(busy & done), 32'd0);
    chk("occ_max", 32'(dut.u_buf.o_count <= 2'd2), 32'd1);
    if (done) done_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    pat_i++;
    case (ready_mode)
      1:       m_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
    case (busy_mode)
      1: wr_busy = ($urandom_range(0, 3) == 0);
      2: begin
        if (!pulse_done && acc_cnt >= 3) begin
          pulse_done = 1'b1;
          pulse_left = 3;
        end
        wr_busy = (pulse_left > 0);
        if (pulse_left > 0) pulse_left--;
      end
      default: wr_busy = 1'b0;
    endcase
    @(negedge clk);
    if (rst_n) mon();
  endtask

  task automatic prep(input logic [ADDR_DW-1:0] b, input int l);
    logic [ADDR_DW-1:0] a;
    exp_q.delete();
    for (int i = 0; i < l; i++) begin
      a = b + ADDR_DW'(i);
      exp_q.push_back(mem[a]);
    end
    exp_addr   = b;
    acc_cnt    = 0;
    deliv      = 0;
    done_cnt   = 0;
    stalled    = 0;
    hold_chk   = 1'b0;
    pulse_done = 1'b0;
    pulse_left = 0;
    base_addr  = b;
    len        = LEN_W'(l);
    start      = 1'b1;
  endtask

  task automatic run(input logic [ADDR_DW-1:0] b, input int l, input bit inj);
    int n;
    int first;
    bit got_done;
    prep(b, l);
    n = 0;
    first = -1;
    got_done = 1'b0;
    while (!got_done && n < 400) begin
      if (inj && n == 4) begin
        start     = 1'b1;
        base_addr = 4'd9;
        len       = 5'd3;
      end
      step();
      n++;
      if (m_valid && first < 0) first = n;
      if (done) got_done = 1'b1;
    end
    chk("done_seen", 32'(got_done), 32'd1);
    if (ready_mode == 0 && busy_mode == 0) begin
      chk("done_cycle", 32'(n), (l == 0) ? 32'd1 : 32'(3 + l));
      if (l > 0) chk("first_valid", 32'(first), 32'd3);
    end
    chk("busy_at_done", 32'(busy), 32'd0);
    step();
    step();
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("words_left", 32'(exp_q.size()), 32'd0);
    chk("reads", 32'(acc_cnt), 32'(l));
    chk("words", 32'(deliv), 32'(l));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_raen"},  32'(RAenable), 32'd0);
    chk({tag, "_addr"},  32'(addr_r),   32'd0);
    chk({tag, "_valid"}, 32'(m_valid),  32'd0);
    chk({tag, "_data"},  32'(m_data),   32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_done"},  32'(done),     32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) + 8'h10;
    ready_mode = 0;
    busy_mode  = 0;
    pat_i      = 0;

    repeat (2) step();
    chk_reset("reset");
    rst_n = 1'b1;
    step();

    // Straight burst, full rate
    run(4'd0, 8, 1'b0);
    // Address wrap
    run(4'd14, 4, 1'b0);
    // Back-pressure pattern
    ready_mode = 1;
    run(4'd0, 8, 1'b0);
    ready_mode = 0;
    // Write-priority stall mid-fetch
    busy_mode = 2;
    run(4'd4, 8, 1'b0);
    chk("stalled_reads", 32'(stalled), 32'd3);
    busy_mode = 0;
    // Zero-length burst, then start while busy
    run(4'd3, 0, 1'b0);
    run(4'd0, 8, 1'b1);

    // Reset in the middle of a burst
    prep(4'd0, 8);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run(4'd5, 3, 1'b0);

    // Randomized bursts with random back-pressure and write stalls
    ready_mode = 2;
    busy_mode  = 1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 255));
      run(ADDR_DW'($urandom_range(0, 15)), $urandom_range(1, 16), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
